// File: rtl/perceptron_result_display.sv
// perceptron_result_display
// Captures the signed 8-bit perceptron result and plays it on one active-high
// 7-segment digit as a repeating sequence: sign, hundreds, tens, ones, gap.
// A single-entry pending buffer holds a newer result until the end of the
// gap. If a newer result overwrites an unshown pending one, dropped pulses.
module perceptron_result_display #(
  parameter logic [23:0] MAX_COUNT = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] result,
  input  logic       result_valid,
  output logic [7:0] seg,
  output logic       busy,
  output logic       dropped
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SIGN = 3'd1,
    HUND = 3'd2,
    TENS = 3'd3,
    ONES = 3'd4,
    GAP  = 3'd5
  } state_t;

  // Dwell counter value loaded on every state entry; it counts down to zero.
  localparam logic [23:0] RELOAD = MAX_COUNT - 24'd1;

  state_t      state_r, state_s;
  logic [23:0] cnt_r, cnt_s;
  logic        sign_r, sign_s;
  logic [3:0]  hund_r, hund_s;
  logic [3:0]  tens_r, tens_s;
  logic [3:0]  ones_r, ones_s;
  logic [7:0]  pend_val_r, pend_val_s;
  logic        pend_full_r, pend_full_s;
  logic        load_en_s;
  logic [7:0]  load_val_s;
  logic [7:0]  mag_s;
  logic        dropped_s;
  logic [7:0]  seg_r, seg_s;
  logic        busy_r;
  logic        dropped_r;

  // Segment pattern for one decimal digit (a = bit 0 ... g = bit 6).
  function automatic logic [7:0] digit_code(input logic [3:0] d);
    logic [7:0] c;
    case (d)
      4'd0:    c = 8'h3F;
      4'd1:    c = 8'h06;
      4'd2:    c = 8'h5B;
      4'd3:    c = 8'h4F;
      4'd4:    c = 8'h66;
      4'd5:    c = 8'h6D;
      4'd6:    c = 8'h7D;
      4'd7:    c = 8'h07;
      4'd8:    c = 8'h7F;
      4'd9:    c = 8'h6F;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Symbol shown while in a given state for a given current value.
  function automatic logic [7:0] symbol(input state_t st, input logic sg,
                                        input logic [3:0] h, input logic [3:0] t,
                                        input logic [3:0] o);
    logic [7:0] c;
    case (st)
      IDLE:    c = 8'h00;
      SIGN:    c = sg ? 8'h40 : 8'h00;
      HUND:    c = digit_code(h);
      TENS:    c = digit_code(t);
      ONES:    c = digit_code(o) | 8'h80;
      GAP:     c = 8'h00;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Next-state, dwell timing, pending buffer and load selection.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    pend_val_s  = pend_val_r;
    pend_full_s = pend_full_r;
    load_en_s   = 1'b0;
    load_val_s  = result;
    dropped_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (result_valid) begin
          load_en_s = 1'b1;
          state_s   = SIGN;
          cnt_s     = RELOAD;
        end else begin
          cnt_s = 24'd0;
        end
      end
      SIGN, HUND, TENS, ONES: begin
        if (cnt_r == 24'd0) begin
          case (state_r)
            SIGN:    state_s = HUND;
            HUND:    state_s = TENS;
            TENS:    state_s = ONES;
            ONES:    state_s = GAP;
            default: state_s = IDLE;
          endcase
          cnt_s = RELOAD;
        end else begin
          cnt_s = cnt_r - 24'd1;
        end
        if (result_valid) begin
          pend_val_s  = result;
          pend_full_s = 1'b1;
          dropped_s   = pend_full_r;
        end else begin
          pend_full_s = pend_full_r;
        end
      end
      GAP: begin
        if (cnt_r == 24'd0) begin
          // End of sequence: a same-cycle strobe beats the older pending value.
          state_s     = SIGN;
          cnt_s       = RELOAD;
          pend_full_s = 1'b0;
          if (result_valid) begin
            load_en_s  = 1'b1;
            load_val_s = result;
            dropped_s  = pend_full_r;
          end else if (pend_full_r) begin
            load_en_s  = 1'b1;
            load_val_s = pend_val_r;
          end else begin
            load_en_s = 1'b0;
          end
        end else begin
          cnt_s = cnt_r - 24'd1;
          if (result_valid) begin
            pend_val_s  = result;
            pend_full_s = 1'b1;
            dropped_s   = pend_full_r;
          end else begin
            pend_full_s = pend_full_r;
          end
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 24'd0;
      end
    endcase
  end

  // Binary-to-decimal conversion of a loaded value and the next symbol.
  always_comb begin
    mag_s = load_val_s[7] ? (8'd0 - load_val_s) : load_val_s;
    if (load_en_s) begin
      sign_s = load_val_s[7];
      hund_s = 4'(mag_s / 8'd100);
      tens_s = 4'((mag_s / 8'd10) % 8'd10);
      ones_s = 4'(mag_s % 8'd10);
    end else begin
      sign_s = sign_r;
      hund_s = hund_r;
      tens_s = tens_r;
      ones_s = ones_r;
    end
    seg_s = symbol(state_s, sign_s, hund_s, tens_s, ones_s);
  end

  // State, value registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= 24'd0;
      sign_r      <= 1'b0;
      hund_r      <= 4'd0;
      tens_r      <= 4'd0;
      ones_r      <= 4'd0;
      pend_val_r  <= 8'd0;
      pend_full_r <= 1'b0;
      seg_r       <= 8'h00;
      busy_r      <= 1'b0;
      dropped_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      sign_r      <= sign_s;
      hund_r      <= hund_s;
      tens_r      <= tens_s;
      ones_r      <= ones_s;
      pend_val_r  <= pend_val_s;
      pend_full_r <= pend_full_s;
      seg_r       <= seg_s;
      busy_r      <= (state_s != IDLE);
      dropped_r   <= dropped_s;
    end
  end

  assign seg     = seg_r;
  assign busy    = busy_r;
  assign dropped = dropped_r;

endmodule

// File: tb/tb_perceptron_result_display.sv
// Testbench for perceptron_result_display (MAX_COUNT = 4).
// Directed scenarios plus random strobes/resets, all checked every cycle
// against a timeline model: the symbol index is elapsed cycles / MAX_COUNT.
module tb_perceptron_result_display;

  localparam int MC = 4;
  localparam logic [7:0] DIGIT_CODE [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                             8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  logic       clk;
  logic       reset;
  logic [7:0] result;
  logic       result_valid;
  logic [7:0] seg;
  logic       busy;
  logic       dropped;

  int n_cmp;
  int n_err;

  // Reference model state
  bit         m_active;
  int         m_t;
  logic [7:0] m_val;
  logic [7:0] m_pend_q[$];
  bit         m_dropped;

  perceptron_result_display #(.MAX_COUNT(24'd4)) dut (
    .clk         (clk),
    .reset       (reset),
    .result      (result),
    .result_valid(result_valid),
    .seg         (seg),
    .busy        (busy),
    .dropped     (dropped)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h (model t=%0d)", tag, got, exp, m_t);
    end
  endtask

  function automatic logic [7:0] exp_symbol(input logic [7:0] v, input int phase);
    int s;
    int mag;
    s   = int'($signed(v));
    mag = (s < 0) ? -s : s;
    case (phase)
      0:       return (s < 0) ? 8'h40 : 8'h00;
      1:       return DIGIT_CODE[mag / 100];
      2:       return DIGIT_CODE[(mag / 10) % 10];
      3:       return DIGIT_CODE[mag % 10] | 8'h80;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_update(input logic r, input logic v, input logic [7:0] d);
    if (r) begin
      m_active  = 1'b0;
      m_t       = 0;
      m_dropped = 1'b0;
      m_pend_q.delete();
    end else if (!m_active) begin
      m_dropped = 1'b0;
      if (v) begin
        m_active = 1'b1;
        m_val    = d;
        m_t      = 0;
      end
    end else begin
      m_dropped = v && (m_pend_q.size() != 0);
      if (m_t == 5 * MC - 1) begin
        if (v) m_val = d;
        else if (m_pend_q.size() != 0) m_val = m_pend_q[0];
        m_pend_q.delete();
        m_t = 0;
      end else begin
        if (v) begin
          m_pend_q.delete();
          m_pend_q.push_back(d);
        end
        m_t++;
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d);
    logic [7:0] exp_seg;
    @(negedge clk);
    reset        = r;
    result_valid = v;
    result       = d;
    @(posedge clk);
    model_update(r, v, d);
    #1;
    exp_seg = m_active ? exp_symbol(m_val, m_t / MC) : 8'h00;
    check("seg", seg, exp_seg);
    check("busy", {7'd0, busy}, {7'd0, m_active});
    check("dropped", {7'd0, dropped}, {7'd0, m_dropped});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    m_active     = 1'b0;
    m_t          = 0;
    m_val        = 8'h00;
    m_dropped    = 1'b0;
    reset        = 1'b1;
    result_valid = 1'b0;
    result       = 8'h00;

    // Reset values, then idle with nothing shown.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
    idle(6);

    // Positive value repeating over more than two sequences.
    step(1'b0, 1'b1, 8'd57);
    idle(45);

    // Most negative value and -1.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h80);
    idle(22);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hFF);
    idle(22);

    // Single pending update strobed during TENS.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'd57);
    for (int i = 1; i <= 45; i++) step(1'b0, i == 10, 8'd5);

    // Overwrite within one sequence: 1 then 2.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'd57);
    for (int i = 1; i <= 45; i++) step(1'b0, (i == 3) || (i == 8), (i == 8) ? 8'd2 : 8'd1);

    // Strobe on the final GAP cycle with a pending value present.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'd57);
    for (int i = 1; i <= 45; i++) step(1'b0, (i == 5) || (i == 20), (i == 20) ? 8'd9 : 8'd3);

    // Reset during HUND with a pending value; stays idle afterwards.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'd57);
    for (int i = 1; i <= 5; i++) step(1'b0, i == 2, 8'd5);
    step(1'b1, 1'b0, 8'h00);
    idle(30);

    // Randomized strobes, values and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic       r;
      logic       v;
      logic [7:0] d;
      r = ($urandom_range(0, 399) == 0);
      v = ($urandom_range(0, 11) == 0);
      d = 8'($urandom);
      step(r, v, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
